// File: rtl/fetch_pkg.sv
// fetch_pkg: FSM states, instruction field layout and PC constants for the fetch stage.
// FETCH_ALIGN_CHECK_EN adds the HALT state.
package fetch_pkg;
`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {BOOT, FETCH, DELIVER, HALT} fetch_state_t;
`else
    typedef enum logic [1:0] {BOOT, FETCH, DELIVER} fetch_state_t;
`endif
    localparam int COND_LSB  = 28;
    localparam int COND_W    = 4;
    localparam int OP_LSB    = 26;
    localparam int OP_W      = 2;
    localparam int FUNCT_LSB = 20;
    localparam int FUNCT_W   = 6;
    localparam int RD_LSB    = 12;
    localparam int RD_W      = 4;
    localparam logic [31:0] INSTR_BYTES    = 32'd4;
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;
endpackage

// File: rtl/instr_fields.sv
// instr_fields: combinational split of an instruction word into cond/op/funct/rd.
module instr_fields
    import fetch_pkg::*;
(
    input  logic [31:0]          i_instr,
    output logic [COND_W-1:0]    o_cond,
    output logic [OP_W-1:0]      o_op,
    output logic [FUNCT_W-1:0]   o_funct,
    output logic [RD_W-1:0]      o_rd
);
    assign o_cond  = i_instr[COND_LSB +: COND_W];
    assign o_op    = i_instr[OP_LSB +: OP_W];
    assign o_funct = i_instr[FUNCT_LSB +: FUNCT_W];
    assign o_rd    = i_instr[RD_LSB +: RD_W];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, single-word req/ack fetch and valid/ready delivery to decode.
// FETCH_ALIGN_CHECK_EN: misaligned branch targets raise a sticky fault and HALT.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [3:0]  cond,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rd,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        fault,
`endif
    output logic [31:0] instr_count
);
    fetch_state_t r_state, w_next;
    logic [31:0] r_pc, r_count, r_instr, w_pc_next;
    logic w_accept;
`ifdef FETCH_ALIGN_CHECK_EN
    logic w_misalign, r_fault;
    assign fault = r_fault;
`endif

    always_comb begin
        w_accept = r_state == DELIVER && instr_ready;
`ifdef FETCH_ALIGN_CHECK_EN
        w_misalign = pc_src && branch_target[1:0] != 2'b00;
        w_pc_next = w_misalign ? r_pc : pc_src ? branch_target : r_pc + INSTR_BYTES;
`else
        w_pc_next = pc_src ? {branch_target[31:2], 2'b00} : r_pc + INSTR_BYTES;
`endif
        w_next = r_state;
        case (r_state)
            BOOT:    w_next = FETCH;
            FETCH:   w_next = imem_ack ? DELIVER : FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
            DELIVER: w_next = !w_accept ? DELIVER : w_misalign ? HALT : FETCH;
`else
            DELIVER: w_next = w_accept ? FETCH : DELIVER;
`endif
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_count <= '0;
            r_instr <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fault <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == FETCH && imem_ack) r_instr <= imem_rdata;
            if (w_accept) begin
                r_pc    <= w_pc_next;
                r_count <= r_count + 32'd1;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            if (w_accept && w_misalign) r_fault <= 1'b1;
`endif
        end
    end

    assign imem_req    = r_state == FETCH;
    assign instr_valid = r_state == DELIVER;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus8    = r_pc + PC_READ_OFFSET;
    assign instr       = r_instr;
    assign instr_count = r_count;

    instr_fields u_fields (
        .i_instr (r_instr),
        .o_cond  (cond),
        .o_op    (op),
        .o_funct (funct),
        .o_rd    (rd)
    );
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the ARM-subset CPU. Owns the program counter, fetches one 32-bit word at a time from instruction memory with a req/ack handshake, and presents it to the decode `Controller` as split fields (`cond`, `op`, `funct`, `rd`) plus the full word. It is the producing end of the controller's instruction interface. It consumes the controller's `pc_src` and the datapath's branch target to redirect the PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: word address of the request; equals `pc`.
- `imem_ack`  in  1: memory has `imem_rdata` valid this cycle. Ignored unless `imem_req` = 1.
- `imem_rdata`  in  32: fetched instruction word.
- `instr_valid`  out  1: fetched instruction is presented downstream.
- `instr_ready`  in  1: downstream accepts the instruction this cycle.
- `instr`  out  32: held instruction word.
- `cond`  out  4: `instr[31:28]`.
- `op`  out  2: `instr[27:26]`.
- `funct`  out  6: `instr[25:20]`.
- `rd`  out  4: `instr[15:12]`.
- `pc`  out  32: address of the held or requested instruction.
- `pc_plus8`  out  32: `pc + 8`, used as the R15 read value.
- `pc_src`  in  1: take the branch. Sampled only on an accept cycle.
- `branch_target`  in  32: next PC when `pc_src` = 1.
- `instr_count`  out  32: number of accepted instructions.
- `fault`  out  1: misaligned-target fault. Present only with `FETCH_ALIGN_CHECK_EN`.

## Operation
- FSM states:
  - **BOOT**
    - Entered on reset.
    - Next cycle: FETCH.
  - **FETCH**
    - Drives `imem_req` = 1 and `imem_addr` = `pc`.
    - If `imem_ack` = 1: capture `imem_rdata` into the instruction register and go to DELIVER.
    - Otherwise: stay in FETCH, holding request and address stable.
  - **DELIVER**
    - Drives `instr_valid` = 1 and `imem_req` = 0.
    - On accept (`instr_valid` && `instr_ready`):
      - `pc` <= `pc_src` ? `branch_target` : `pc` + 4.
      - `instr_count` += 1.
      - Next state: FETCH.
    - Otherwise: hold everything.
  - **HALT**
    - Only with `FETCH_ALIGN_CHECK_EN`.
    - `imem_req` = 0, `instr_valid` = 0.
    - Exited only by reset.
- Field outputs are combinational slices of the instruction register. They are stable throughout DELIVER.
- Arithmetic rules:
  - `pc` + 4, `pc_plus8` and `instr_count` are 32-bit modulo; wrap silently.
  - `pc` = 32'hFFFF_FFFC followed by a sequential accept gives `pc` = 0.
  - `instr_count` = 32'hFFFF_FFFF followed by an accept gives 0.
- `pc_src` and `branch_target` outside an accept cycle have no effect.
- Reset values:
  - State: BOOT.
  - `pc` = `RESET_PC`; `instr_count` = 0; instruction register = 0.
  - `imem_req` = 0, `instr_valid` = 0, `fault` = 0.
- Reset during FETCH abandons the request. A same-cycle `imem_ack` is discarded and memory must tolerate the drop.
- Reset during DELIVER discards the held instruction. A same-cycle `instr_ready` does not count as an accept.

## Timing
- Reset is released before edge N. Then:
  - Cycle N: BOOT.
  - Cycle N+1: first FETCH, with `imem_addr` = `RESET_PC`.
- Zero-wait memory (ack in the same cycle as req):
  - Fetch-to-valid latency is 1 cycle.
  - Minimum throughput is 1 instruction per 2 cycles.
- Each memory wait cycle adds one cycle.
- `instr_ready` may be asserted before `instr_valid`. It has no effect until `instr_valid` = 1.
- A redirected PC is visible on `imem_addr` in the cycle after the accept.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - An accept with `pc_src` = 1 and `branch_target[1:0]` != 0 sets `fault` and enters HALT.
  - `pc` is left unchanged.
  - `instr_count` still increments.
  - `fault` is sticky until reset.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `branch_target[1:0]` is forced to 0 on load.
  - `fault` port is omitted and the HALT state does not exist.

## Structure
- Package `fetch_pkg`:
  - FSM state enum `fetch_state_t` (BOOT, FETCH, DELIVER, HALT).
  - Field LSB/width constants for COND, OP, FUNCT, RD.
  - `INSTR_BYTES` = 4 and `PC_READ_OFFSET` = 8.
- Sub-module `instr_fields`: purely combinational split of the instruction word into `cond`/`op`/`funct`/`rd`. It is instantiated once and is reusable by later decode/pipeline stages.

## Test plan
- **Reset and first fetch:** reset 2 cycles, `RESET_PC` = 32'h100 -> `imem_req` = 0 during reset and BOOT; FETCH with `imem_addr` = 32'h100 on cycle N+1.
- **Sequential fetch:** zero-wait memory returning 32'hE281_1004 (`cond` 1110, `op` 00, `funct` 101000, `rd` 0001), `instr_ready` = 1 -> `instr_valid` on alternate cycles; addresses 32'h100, 32'h104, 32'h108; `pc_plus8` = 32'h108 while `pc` = 32'h100; `instr_count` = 3 after three accepts.
- **Backpressure and wait states:** `imem_ack` delayed 3 cycles with address held stable; then `instr_ready` low for 4 cycles -> `instr`, fields and `pc` constant; exactly one `instr_count` increment.
- **Branch:** accept with `pc_src` = 1, `branch_target` = 32'h40 -> next `imem_addr` = 32'h40; `pc_src` = 1 outside an accept is ignored.
- **Wrap:** `pc` = 32'hFFFF_FFFC with a sequential accept -> `pc` = 0; `instr_count` preloaded by 2^32 accepts (or forced) from 32'hFFFF_FFFF -> 0.
- **Alignment and reset mid-fetch:** with `FETCH_ALIGN_CHECK_EN`, `branch_target` = 32'h42 -> `fault` = 1, HALT, no further `imem_req`; without the macro, next address is 32'h40. Reset asserted in FETCH with a simultaneous ack -> data discarded, restart at `RESET_PC`.
